// File: rtl/mul_pkg.sv
// Shared multiplier definitions: FSM state encodings and default operand width.
package mul_pkg;
  localparam int MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;
endpackage

// File: rtl/mul_int_seq_if.sv
// Start/done handshake and operand/product bus of the sequential multiplier.
import mul_pkg::*;

interface mul_int_seq_if #(
  parameter int WIDTH = MUL_WIDTH
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] p;

  modport master (output start, a, b, input busy, done, p);
  modport slave  (input start, a, b, output busy, done, p);
endinterface

// File: rtl/mul_int_seq_step.sv
// One radix-2 shift-add iteration, purely combinational.
import mul_pkg::*;

module mul_step #(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_nx,
  output logic [2*WIDTH-1:0] mcand_nx,
  output logic [WIDTH-1:0]   mplier_nx,
  output logic               zero
);
  assign acc_nx    = mplier[0] ? acc + mcand : acc;
  assign mcand_nx  = mcand << 1;
  assign mplier_nx = mplier >> 1;
  assign zero      = (mplier_nx == '0);
endmodule

// File: rtl/mul_int_seq.sv
// Sequential shift-add unsigned multiplier, one partial product per clock.
// Optional macro MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
import mul_pkg::*;

module mul_int_seq #(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = 6
) (
  input logic          clk,
  input logic          rst_n,
  mul_int_seq_if.slave bus
);
  mul_state_t         state, state_nx;
  logic [2*WIDTH-1:0] acc, mcand, acc_nx, mcand_nx, p;
  logic [WIDTH-1:0]   mplier, mplier_nx;
  logic [CNT_W-1:0]   cnt;
  logic               zero, last, finish, accept;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .mplier   (mplier),
    .acc_nx   (acc_nx),
    .mcand_nx (mcand_nx),
    .mplier_nx(mplier_nx),
    .zero     (zero)
  );

  assign accept = bus.start && (state != MUL_RUN);
  assign last   = (cnt == CNT_W'(WIDTH-1));

`ifdef MUL_EARLY_TERM_EN
  assign finish = last || zero;
`else
  // After WIDTH shifts the multiplier is necessarily empty, so zero always holds with last.
  assign finish = last && zero;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      MUL_IDLE: if (accept) state_nx = MUL_RUN;
      MUL_RUN:  if (finish) state_nx = MUL_DONE;
      MUL_DONE: state_nx = accept ? MUL_RUN : MUL_IDLE;
      default:  state_nx = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MUL_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      p      <= '0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, bus.a};
      mplier <= bus.b;
      cnt    <= '0;
    end else if (state == MUL_RUN) begin
      acc    <= acc_nx;
      mcand  <= mcand_nx;
      mplier <= mplier_nx;
      cnt    <= cnt + CNT_W'(1);
      if (finish) p <= acc_nx;
    end
  end

  assign bus.busy = (state == MUL_RUN);
  assign bus.done = (state == MUL_DONE);
  assign bus.p    = p;
endmodule
